// File: rtl/aes_pkg.sv
// Shared AES definitions: default job sizes, the S-box scheduler FSM encoding
// and the byte-index to bit-position helper.
package aes_pkg;

    localparam int unsigned STATE_BYTES_DEFAULT = 16;
    localparam int unsigned KEY_BYTES_DEFAULT   = 4;

    typedef enum logic [2:0] {
        IDLE,
        RUN_STATE,
        RUN_KEY,
        DONE_STATE,
        DONE_KEY
    } sbox_sched_state_t;

    // Byte 0 is the most significant byte of an nbytes-wide word.
    function automatic int unsigned byte_msb(input int unsigned nbytes, input logic [3:0] idx);
        return 8 * nbytes - 1 - 8 * 32'(idx);
    endfunction

endpackage

// File: rtl/sbytes.sv
// Combinational AES forward S-box for one byte. The output is forced to zero
// when the lookup is not enabled so an idle path stays quiet.
module sbytes (
    input  logic [7:0] olddata,
    input  logic       sbytes_enable,
    output logic [7:0] newdata
);

    // Entry x sits at bits [2047-8x -: 8].
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // ~{x,3'b000} equals 2047-8x, the MSB of entry x.
    assign newdata = sbytes_enable ? SBOX_TABLE[~{olddata, 3'b000} -: 8] : 8'h00;

endmodule

// File: rtl/sbox_sched.sv
// Round-robin, non-preemptive sequencer sharing one S-box between the round
// datapath (SubBytes) and key expansion (SubWord), one byte per clock.
module sbox_sched
    import aes_pkg::*;
#(
    parameter int unsigned STATE_BYTES = STATE_BYTES_DEFAULT,
    parameter int unsigned KEY_BYTES   = KEY_BYTES_DEFAULT
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic                     state_req,
    input  logic [8*STATE_BYTES-1:0] state_in,
    output logic                     state_done,
    output logic [8*STATE_BYTES-1:0] state_out,
    input  logic                     key_req,
    input  logic [8*KEY_BYTES-1:0]   key_in,
    output logic                     key_done,
    output logic [8*KEY_BYTES-1:0]   key_out,
    output logic                     busy
);

    sbox_sched_state_t fsm_reg, fsm_next;

    logic [3:0]               count_reg;
    logic                     last_key_reg;
    logic [8*STATE_BYTES-1:0] state_out_reg;
    logic [8*KEY_BYTES-1:0]   key_out_reg;

    logic       grant_state;
    logic       grant_key;
    logic       count_last;
    logic       sbytes_enable;
    logic [7:0] olddata;
    logic [7:0] newdata;

    sbytes u_sbytes (
        .olddata       (olddata),
        .sbytes_enable (sbytes_enable),
        .newdata       (newdata)
    );

    always_comb begin
        fsm_next      = fsm_reg;
        grant_state   = 1'b0;
        grant_key     = 1'b0;
        count_last    = 1'b0;
        sbytes_enable = 1'b0;
        olddata       = 8'h00;
        case (fsm_reg)
            IDLE: begin
                // On a tie, serve whoever was not granted last.
                if (state_req && key_req) begin
                    grant_state = last_key_reg;
                    grant_key   = !last_key_reg;
                end else begin
                    grant_state = state_req;
                    grant_key   = key_req;
                end
                if (grant_state) begin
                    fsm_next = RUN_STATE;
                end else if (grant_key) begin
                    fsm_next = RUN_KEY;
                end
            end
            RUN_STATE: begin
                sbytes_enable = 1'b1;
                olddata       = state_out_reg[byte_msb(STATE_BYTES, count_reg) -: 8];
                count_last    = (count_reg == 4'(STATE_BYTES - 1));
                if (count_last) begin
                    fsm_next = DONE_STATE;
                end
            end
            RUN_KEY: begin
                sbytes_enable = 1'b1;
                olddata       = key_out_reg[byte_msb(KEY_BYTES, count_reg) -: 8];
                count_last    = (count_reg == 4'(KEY_BYTES - 1));
                if (count_last) begin
                    fsm_next = DONE_KEY;
                end
            end
            DONE_STATE: fsm_next = IDLE;
            DONE_KEY:   fsm_next = IDLE;
            default:    fsm_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            fsm_reg       <= IDLE;
            count_reg     <= 4'd0;
            last_key_reg  <= 1'b0;
            state_out_reg <= '0;
            key_out_reg   <= '0;
        end else begin
            fsm_reg <= fsm_next;
            if (grant_state) begin
                state_out_reg <= state_in;
                count_reg     <= 4'd0;
                last_key_reg  <= 1'b0;
            end else if (grant_key) begin
                key_out_reg  <= key_in;
                count_reg    <= 4'd0;
                last_key_reg <= 1'b1;
            end else if (fsm_reg == RUN_STATE) begin
                state_out_reg[byte_msb(STATE_BYTES, count_reg) -: 8] <= newdata;
                count_reg <= count_last ? count_reg : count_reg + 4'd1;
            end else if (fsm_reg == RUN_KEY) begin
                key_out_reg[byte_msb(KEY_BYTES, count_reg) -: 8] <= newdata;
                count_reg <= count_last ? count_reg : count_reg + 4'd1;
            end
        end
    end

    assign state_out  = state_out_reg;
    assign key_out    = key_out_reg;
    assign state_done = (fsm_reg == DONE_STATE);
    assign key_done   = (fsm_reg == DONE_KEY);
    assign busy       = (fsm_reg != IDLE);

endmodule

// File: tb/tb_sbox_sched.sv
// Self-checking bench for sbox_sched: vector table of single jobs plus
// hand-written tie, held-request and mid-job reset sequences, with a scoreboard.
module tb_sbox_sched;

    logic         clk;
    logic         n_rst;
    logic         state_req;
    logic [127:0] state_in;
    logic         state_done;
    logic [127:0] state_out;
    logic         key_req;
    logic [31:0]  key_in;
    logic         key_done;
    logic [31:0]  key_out;
    logic         busy;

    sbox_sched dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .state_req  (state_req),
        .state_in   (state_in),
        .state_done (state_done),
        .state_out  (state_out),
        .key_req    (key_req),
        .key_in     (key_in),
        .key_done   (key_done),
        .key_out    (key_out),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit           is_key;
        logic [127:0] dout;
        int           done_cyc;
    } exp_t;

    typedef struct {
        bit           is_key;
        logic [127:0] din;
        logic [127:0] dout;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[8];

    int cyc = 0;
    int checks = 0;
    int failures = 0;

    bit           guard_state_en = 1'b0;
    logic [127:0] guard_state_val = '0;
    bit           guard_key_en = 1'b0;
    logic [31:0]  guard_key_val = '0;
    logic [127:0] last_state_out = '0;
    logic [31:0]  last_key_out = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Scoreboard monitor: every done pulse must match the oldest expectation.
    always @(negedge clk) begin : mon
        exp_t e;
        if (state_done || key_done) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL spurious_done actual=state:%0b key:%0b required=none (cycle %0d)",
                         state_done, key_done, cyc);
            end else begin
                e = sb.pop_front();
                check("done_kind", {126'd0, key_done, state_done}, e.is_key ? 128'd2 : 128'd1);
                check("done_cycle", 128'(cyc), 128'(e.done_cyc));
                if (e.is_key) check("key_out", {96'd0, key_out}, e.dout);
                else          check("state_out", state_out, e.dout);
                $display("txn %s done cyc=%0d out=%h", e.is_key ? "key  " : "state",
                         cyc, e.is_key ? {96'd0, key_out} : state_out);
            end
        end
        if (guard_state_en) check("state_out_hold", state_out, guard_state_val);
        if (guard_key_en)   check("key_out_hold", {96'd0, key_out}, {96'd0, guard_key_val});
    end

    task automatic wait_done(input bit is_key, input bit drop);
        int  n = 0;
        bit  seen = 1'b0;
        while (!seen && n < 40) begin
            @(negedge clk);
            n++;
            if (is_key ? key_done : state_done) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL done_timeout actual=no_%s_done required=%s_done", is_key ? "key" : "state",
                     is_key ? "key" : "state");
            sb.delete();
        end
        if (drop) begin
            if (is_key) key_req = 1'b0;
            else        state_req = 1'b0;
        end
    endtask

    task automatic run_job(input vec_t v);
        @(negedge clk);
        check("busy_idle", {127'd0, busy}, 128'd0);
        if (v.is_key) begin
            guard_state_en  = 1'b1;
            guard_state_val = last_state_out;
            key_in  = v.din[31:0];
            key_req = 1'b1;
            sb.push_back('{1'b1, v.dout, cyc + 5});
        end else begin
            guard_key_en  = 1'b1;
            guard_key_val = last_key_out;
            state_in  = v.din;
            state_req = 1'b1;
            sb.push_back('{1'b0, v.dout, cyc + 17});
        end
        wait_done(v.is_key, 1'b1);
        guard_state_en = 1'b0;
        guard_key_en   = 1'b0;
        if (v.is_key) last_key_out = v.dout[31:0];
        else          last_state_out = v.dout;
    endtask

    task automatic run_tie(input logic [31:0] kin, input logic [31:0] kout,
                           input logic [127:0] sin, input logic [127:0] sout);
        @(negedge clk);
        key_in    = kin;
        state_in  = sin;
        key_req   = 1'b1;
        state_req = 1'b1;
        sb.push_back('{1'b1, {96'd0, kout}, cyc + 5});
        sb.push_back('{1'b0, sout, cyc + 23});
        wait_done(1'b1, 1'b1);
        wait_done(1'b0, 1'b1);
        last_key_out   = kout;
        last_state_out = sout;
    endtask

    initial begin
        int t0;
        vecs[0] = '{1'b1, 128'h4300FF74, 128'h1A631692};
        vecs[1] = '{1'b1, 128'h01234567, 128'h7C266E85};
        vecs[2] = '{1'b0, 128'h00010203_04050607_08090A0B_0C0D0E0F,
                          128'h637C777B_F26B6FC5_3001672B_FED7AB76};
        vecs[3] = '{1'b1, 128'h53CA8C10, 128'hED7464CA};
        vecs[4] = '{1'b0, {16{8'h11}}, {16{8'h82}}};
        vecs[5] = '{1'b1, 128'hFFFFFFFF, 128'h16161616};
        vecs[6] = '{1'b0, 128'h4300FF74_61000000_00000000_00000000,
                          128'h1A631692_EF636363_63636363_63636363};
        vecs[7] = '{1'b0, {16{8'hFF}}, {16{8'h16}}};

        n_rst     = 1'b1;
        state_req = 1'b0;
        key_req   = 1'b0;
        state_in  = '0;
        key_in    = '0;
        #2 n_rst = 1'b0;
        #1;
        check("rst_state_out", state_out, 128'd0);
        check("rst_key_out", {96'd0, key_out}, 128'd0);
        check("rst_busy", {127'd0, busy}, 128'd0);
        check("rst_dones", {126'd0, state_done, key_done}, 128'd0);
        repeat (2) @(negedge clk);
        n_rst = 1'b1;

        // Tie straight after reset goes to key; the next tie goes to key again.
        run_tie(32'h4300FF74, 32'h1A631692,
                128'h4300FF74_61000000_00000000_00000000,
                128'h1A631692_EF636363_63636363_63636363);
        run_tie(32'h00000000, 32'h63636363,
                128'h00010203_04050607_08090A0B_0C0D0E0F,
                128'h637C777B_F26B6FC5_3001672B_FED7AB76);

        for (int i = 0; i < 8; i++) run_job(vecs[i]);

        // Held key request: second job uses the input present at the regrant.
        @(negedge clk);
        guard_state_en  = 1'b1;
        guard_state_val = last_state_out;
        key_in  = 32'h53CA8C10;
        key_req = 1'b1;
        t0 = cyc;
        sb.push_back('{1'b1, 128'hED7464CA, t0 + 5});
        sb.push_back('{1'b1, 128'h16161616, t0 + 11});
        wait_done(1'b1, 1'b0);
        key_in = 32'hFFFFFFFF;
        wait_done(1'b1, 1'b1);
        guard_state_en = 1'b0;
        last_key_out   = 32'h16161616;

        // Reset in the middle of a state job: abort, no done afterwards.
        @(negedge clk);
        state_in  = {16{8'h11}};
        state_req = 1'b1;
        repeat (8) @(negedge clk);
        check("mid_busy", {127'd0, busy}, 128'd1);
        #2 n_rst = 1'b0;
        #1;
        check("mid_rst_state_out", state_out, 128'd0);
        check("mid_rst_key_out", {96'd0, key_out}, 128'd0);
        check("mid_rst_busy", {127'd0, busy}, 128'd0);
        check("mid_rst_dones", {126'd0, state_done, key_done}, 128'd0);
        state_req = 1'b0;
        @(negedge clk);
        n_rst = 1'b1;
        repeat (25) @(negedge clk);
        check("post_rst_busy", {127'd0, busy}, 128'd0);
        check("post_rst_state_out", state_out, 128'd0);
        last_state_out = '0;
        last_key_out   = '0;

        run_job(vecs[0]);
        repeat (3) @(negedge clk);
        check("sb_empty", 128'(sb.size()), 128'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/sbox_sched.md
# sbox_sched

Sequencer and arbiter for the single shared `sbytes` S-box lookup in the AES core. Two requesters share it: the round datapath (SubBytes over the full 128-bit state) and key expansion (SubWord over one 32-bit word). The block latches a request, streams one byte per clock through `sbytes`, writes each substituted byte back into that requester's working register, and pulses a per-requester done. Arbitration is non-preemptive round-robin.

## Interface
Parameters:
- `STATE_BYTES`, 16: bytes per state job.
- `KEY_BYTES`, 4: bytes per key job.

Ports:
- `clk` in 1: system clock, rising edge.
- `n_rst` in 1: reset, asynchronous, active-low.
- `state_req` in 1: round datapath requests SubBytes; level, sampled only in IDLE.
- `state_in` in 128: state to substitute; latched in the grant cycle.
- `state_done` out 1: one-cycle pulse, `state_out` complete.
- `state_out` out 128: substituted state.
- `key_req` in 1: key expansion requests SubWord; level, sampled only in IDLE.
- `key_in` in 32: word to substitute; latched in the grant cycle.
- `key_done` out 1: one-cycle pulse, `key_out` complete.
- `key_out` out 32: substituted word.
- `busy` out 1: high in any state other than IDLE.

## Operation
- Byte order: index k=0 is the MSB byte. State byte k is bits [127-8k -: 8]; key byte k is bits [31-8k -: 8].
- FSM states: IDLE, RUN_STATE, RUN_KEY, DONE_STATE, DONE_KEY.
- IDLE, one request only: grant it. Copy the input to that requester's working register (`state_out` or `key_out` register), clear the byte counter, and go to RUN_x.
- IDLE, both requests: grant the requester not served last (`last_key` flag). The reset preference is the key requester. `last_key` updates on every grant.
- RUN_x: drive `sbytes_enable`=1 and `olddata`=working byte[count]. On the clock edge, write `newdata` into working byte[count] and increment count. After writing byte N-1 (N=16 or 4), go to DONE_x.
- DONE_x: assert the matching done for exactly one cycle, then return to IDLE.
- Outside RUN_x: `sbytes_enable`=0 and `olddata`=8'h00.
- Requests arriving while not in IDLE are not lost. They are honored in the next IDLE cycle, provided they are still asserted.
- A requester must drop its req in the cycle it sees done. A req still high in the following IDLE cycle starts a new job using the current input.
- Each output register is modified only during its own requester's job. A key job never disturbs `state_out`, and a state job never disturbs `key_out`.
- Counter: 4 bits, no wrap. The FSM leaves RUN at count N-1.

## Timing
- Reset values: FSM IDLE; `state_out`=0; `key_out`=0; count=0; `state_done`=`key_done`=0; `busy`=0; `last_key`=0, so the key requester wins the first tie.
- Latency from req sampled in IDLE (cycle 0) to done high:
  - state job: done high in cycle 17.
  - key job: done high in cycle 5.
  - The output is valid from the done cycle and held until that requester's next grant.
- Back-to-back jobs need one IDLE cycle between them. Minimum request spacing is N+2 cycles.
- Throughput: one S-box lookup per cycle while in RUN.
- Reset mid-job: abort immediately. All registers return to their reset values, no done is issued, and the partial result is discarded.
- The `sbytes` path is combinational. `olddata` to `newdata` must settle within one cycle.

## Structure
- Shared package `aes_pkg` holds:
  - `STATE_BYTES`/`KEY_BYTES` defaults.
  - The FSM enum `sbox_sched_state_t`.
  - The byte-select helper function (index to bit slice).
- One sub-module: the existing `sbytes`, instantiated once with ports `olddata`, `sbytes_enable`, `newdata`. No other hierarchy.

## Test plan
- Reset: assert `n_rst`=0 mid-run. All outputs go to 0 and `busy`=0 asynchronously; no done follows release.
- Key job: `key_in`=32'h4300FF74, pulse `key_req`. `key_done` is high in cycle 5 and `key_out`=32'h1A631692.
- State job: `state_in` = 43 00 FF 74 61, then 11×00. `state_done` is high in cycle 17 and `state_out` = 1A 63 16 92 EF, then 11×63.
- Simultaneous requests after reset: key is granted first (`key_done` at cycle 5), then state (`state_done` at cycle 23). A second tie is granted to key again only after state has been served.
- Independence: run a key job while `state_out` holds a prior result. `state_out` is unchanged throughout.
- Held request: keep `key_req` high through `key_done`. A second key job starts in the following IDLE cycle and `key_done` pulses again 6 cycles later.
